// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline stage with word-organised data memory
//
// Purpose: performs the memory access of one instruction per cycle (byte,
// halfword or word loads and stores with alignment checking), selects the
// writeback value and registers it into the MEM/WB pipeline register.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset (clears registered outputs only)
//   en            stage enable; 0 stalls the register and blocks stores
//   ALU_in        memory byte address / ALU result
//   pcm_in        PC of the instruction
//   datareg_in    store data
//   regdindex_in  destination register index
//   WBsel_in      writeback select: 00 load, 01 ALU, 10 pc+4, 11 zero
//   MEMRw_in      1 = store
//   Rsel_in       load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//   Wsel_in       store size: 00 sb, 01 sh, 10 sw, 11 none
//   Regwrite_in   register write request
//   wb_data_out   registered writeback value
//   regdindex_out registered destination index
//   Regwrite_out  registered register-file write enable
//   misalign_out  registered misaligned-access flag

module mem_wb_stage #(
   parameter int datawidth = 32,
   parameter int regindex  = 5,
   parameter int memwords  = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [datawidth-1:0] ALU_in,
   input  logic [datawidth-1:0] pcm_in,
   input  logic [datawidth-1:0] datareg_in,
   input  logic [regindex-1:0]  regdindex_in,
   input  logic [1:0]           WBsel_in,
   input  logic                 MEMRw_in,
   input  logic [2:0]           Rsel_in,
   input  logic [1:0]           Wsel_in,
   input  logic                 Regwrite_in,
   output logic [datawidth-1:0] wb_data_out,
   output logic [regindex-1:0]  regdindex_out,
   output logic                 Regwrite_out,
   output logic                 misalign_out
);

   localparam int aw = $clog2(memwords);

   typedef enum logic [1:0] {
      SZ_NONE = 2'd0,
      SZ_BYTE = 2'd1,
      SZ_HALF = 2'd2,
      SZ_WORD = 2'd3
   } size_t;

   logic [datawidth-1:0] mem [memwords];

   logic [aw-1:0]        word_addr;
   logic [datawidth-1:0] rd_word;
   logic [7:0]           rd_byte;
   logic [15:0]          rd_half;
   size_t                load_size;
   size_t                acc_size;
   logic                 load_bad;
   logic                 misalign;
   logic [datawidth-1:0] load_data;
   logic [datawidth-1:0] wb_data;
   logic [datawidth-1:0] wr_word;
   logic                 store_en;

   // Address bits above the memory range are ignored, so accesses wrap.
   assign word_addr = ALU_in[aw+1:2];
   assign rd_word   = mem[word_addr];
   assign rd_byte   = rd_word[{ALU_in[1:0], 3'b000} +: 8];
   assign rd_half   = ALU_in[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      load_size = SZ_NONE;
      case (Rsel_in)
         3'b000, 3'b100: load_size = SZ_BYTE;
         3'b001, 3'b101: load_size = SZ_HALF;
         3'b010:         load_size = SZ_WORD;
         default:        load_size = SZ_NONE;
      endcase
   end

   // The flag reports the store size when storing, otherwise the load size
   // only when the writeback actually consumes load data.
   always_comb begin
      acc_size = SZ_NONE;
      if (MEMRw_in) begin
         case (Wsel_in)
            2'b00:   acc_size = SZ_BYTE;
            2'b01:   acc_size = SZ_HALF;
            2'b10:   acc_size = SZ_WORD;
            default: acc_size = SZ_NONE;
         endcase
      end else if (WBsel_in == 2'b00) begin
         acc_size = load_size;
      end
   end

   assign misalign = ((acc_size == SZ_HALF) && ALU_in[0]) ||
                     ((acc_size == SZ_WORD) && (ALU_in[1:0] != 2'b00));

   assign load_bad = ((load_size == SZ_HALF) && ALU_in[0]) ||
                     ((load_size == SZ_WORD) && (ALU_in[1:0] != 2'b00));

   always_comb begin
      load_data = '0;
      if (!load_bad) begin
         case (Rsel_in)
            3'b000:  load_data = {{(datawidth-8){rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{(datawidth-16){rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {{(datawidth-8){1'b0}}, rd_byte};
            3'b101:  load_data = {{(datawidth-16){1'b0}}, rd_half};
            default: load_data = '0;
         endcase
      end
   end

   always_comb begin
      wb_data = '0;
      case (WBsel_in)
         2'b00:   wb_data = load_data;
         2'b01:   wb_data = ALU_in;
         2'b10:   wb_data = pcm_in + datawidth'(4);
         default: wb_data = '0;
      endcase
   end

   // Read-modify-write of the addressed word keeps the memory a plain
   // word array with a single write port.
   always_comb begin
      wr_word = rd_word;
      case (Wsel_in)
         2'b00:   wr_word[{ALU_in[1:0], 3'b000} +: 8] = datareg_in[7:0];
         2'b01:   wr_word[{ALU_in[1], 4'b0000} +: 16] = datareg_in[15:0];
         2'b10:   wr_word = datareg_in;
         default: wr_word = rd_word;
      endcase
   end

   assign store_en = rst && en && MEMRw_in && (Wsel_in != 2'b11) && !misalign;

   // No reset on the array: contents survive rst.
   always_ff @(posedge clk) begin
      if (store_en) begin
         mem[word_addr] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_data_out   <= '0;
         regdindex_out <= '0;
         Regwrite_out  <= 1'b0;
         misalign_out  <= 1'b0;
      end else if (en) begin
         wb_data_out   <= wb_data;
         regdindex_out <= regdindex_in;
         Regwrite_out  <= Regwrite_in && (regdindex_in != '0) && !misalign;
         misalign_out  <= misalign;
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [31:0] alu = '0, pcm = '0, data = '0;
   logic [4:0]  rd = '0;
   logic [1:0]  wbsel = 2'b01;
   logic        memrw = 1'b0;
   logic [2:0]  rsel = 3'b010;
   logic [1:0]  wsel = 2'b11;
   logic        regw = 1'b0;

   logic [31:0] wb_data_out;
   logic [4:0]  regdindex_out;
   logic        Regwrite_out;
   logic        misalign_out;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: byte-addressed memory plus expected register contents.
   logic [7:0]  mm [1024];
   logic [31:0] exp_wb = '0;
   logic [4:0]  exp_rd = '0;
   logic        exp_rw = 1'b0;
   logic        exp_mis = 1'b0;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .en(en),
      .ALU_in(alu), .pcm_in(pcm), .datareg_in(data),
      .regdindex_in(rd), .WBsel_in(wbsel), .MEMRw_in(memrw),
      .Rsel_in(rsel), .Wsel_in(wsel), .Regwrite_in(regw),
      .wb_data_out(wb_data_out), .regdindex_out(regdindex_out),
      .Regwrite_out(Regwrite_out), .misalign_out(misalign_out)
   );

   function automatic int unsigned ld_bytes(input logic [2:0] r);
      case (r)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic int unsigned st_bytes(input logic [1:0] w);
      case (w)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   // Drive current inputs for one clock and advance the model.
   task automatic apply_cycle();
      int unsigned a, acc, ls, ss;
      logic [31:0] ld, nwb;
      logic        mis;
      a   = alu % 1024;
      acc = memrw ? st_bytes(wsel) : ((wbsel == 2'b00) ? ld_bytes(rsel) : 0);
      mis = (acc > 1) && (a % acc != 0);
      ls  = ld_bytes(rsel);
      ld  = '0;
      if (ls != 0 && a % ls == 0) begin
         for (int i = 0; i < int'(ls); i++) ld = ld | (32'(mm[a + i]) << (8 * i));
         if (!rsel[2] && ls < 4 && ld[8 * ls - 1]) ld = ld | (32'hFFFF_FFFF << (8 * ls));
      end
      case (wbsel)
         2'b00:   nwb = ld;
         2'b01:   nwb = alu;
         2'b10:   nwb = pcm + 32'd4;
         default: nwb = '0;
      endcase
      ss = st_bytes(wsel);
      @(posedge clk);
      #1;
      if (!rst) begin
         exp_wb = '0; exp_rd = '0; exp_rw = 1'b0; exp_mis = 1'b0;
      end else if (en) begin
         exp_wb  = nwb;
         exp_rd  = rd;
         exp_rw  = regw && (rd != 0) && !mis;
         exp_mis = mis;
         if (memrw && ss != 0 && !mis)
            for (int i = 0; i < int'(ss); i++) mm[a + i] = data[8 * i +: 8];
      end
   endtask

   task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                         input logic [1:0] wb, input logic mw, input logic [2:0] rs,
                         input logic [1:0] ws, input logic rw);
      alu = a; data = d; rd = r; wbsel = wb; memrw = mw; rsel = rs; wsel = ws; regw = rw;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b1;
      set_op(32'h44, 32'h1, 5'd3, 2'b01, 1'b0, 3'b010, 2'b11, 1'b1);
      @(posedge clk); @(posedge clk); #1;
      tests_run++;
      if (wb_data_out !== 32'h0 || regdindex_out !== 5'h0 || Regwrite_out !== 1'b0 || misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_state: wb=%h rd=%h rw=%b mis=%b required all zero",
                  wb_data_out, regdindex_out, Regwrite_out, misalign_out);
      end
      rst = 1'b1;
      apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'h44 || regdindex_out !== 5'd3 || Regwrite_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_capture: wb=%h rd=%0d rw=%b required 00000044 3 1",
                  wb_data_out, regdindex_out, Regwrite_out);
      end
   endtask

   task automatic test_init();
      for (int w = 0; w < 256; w++) begin
         set_op(32'(w * 4), $urandom, 5'd0, 2'b01, 1'b1, 3'b010, 2'b10, 1'b0);
         apply_cycle();
      end
      tests_run++;
      if (wb_data_out !== 32'h3FC || Regwrite_out !== 1'b0 || misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL init_fill: wb=%h rw=%b mis=%b required 000003fc 0 0",
                  wb_data_out, Regwrite_out, misalign_out);
      end
   endtask

   task automatic test_directed();
      logic [31:0] req [9];
      string       nm [9];
      set_op(32'h10, 32'hDEADBEEF, 5'd0, 2'b01, 1'b1, 3'b010, 2'b10, 1'b0); apply_cycle();
      set_op(32'h10, 32'h0, 5'd5, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'hDEADBEEF || regdindex_out !== 5'd5 || Regwrite_out !== 1'b1 || misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL sw_lw: wb=%h rd=%0d rw=%b mis=%b required deadbeef 5 1 0",
                  wb_data_out, regdindex_out, Regwrite_out, misalign_out);
      end
      req[0] = 32'hFFFFFFDE; nm[0] = "lb_13";
      req[1] = 32'h000000DE; nm[1] = "lbu_13";
      req[2] = 32'hFFFFDEAD; nm[2] = "lh_12";
      req[3] = 32'h0000BEEF; nm[3] = "lhu_10";
      for (int k = 0; k < 4; k++) begin
         case (k)
            0: set_op(32'h13, 0, 5'd6, 2'b00, 1'b0, 3'b000, 2'b11, 1'b1);
            1: set_op(32'h13, 0, 5'd6, 2'b00, 1'b0, 3'b100, 2'b11, 1'b1);
            2: set_op(32'h12, 0, 5'd6, 2'b00, 1'b0, 3'b001, 2'b11, 1'b1);
            default: set_op(32'h10, 0, 5'd6, 2'b00, 1'b0, 3'b101, 2'b11, 1'b1);
         endcase
         apply_cycle();
         tests_run++;
         if (wb_data_out !== req[k]) begin
            tests_failed++;
            $display("FAIL %s: wb=%h required %h", nm[k], wb_data_out, req[k]);
         end
      end
      set_op(32'h11, 32'h55, 5'd0, 2'b01, 1'b1, 3'b010, 2'b00, 1'b0); apply_cycle();
      set_op(32'h10, 0, 5'd8, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'hDEAD55EF) begin
         tests_failed++;
         $display("FAIL sb_merge: wb=%h required dead55ef", wb_data_out);
      end
      set_op(32'h11, 32'h1234, 5'd3, 2'b01, 1'b1, 3'b010, 2'b01, 1'b1); apply_cycle();
      tests_run++;
      if (misalign_out !== 1'b1 || Regwrite_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL sh_misalign: mis=%b rw=%b required 1 0", misalign_out, Regwrite_out);
      end
      set_op(32'h10, 0, 5'd8, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'hDEAD55EF) begin
         tests_failed++;
         $display("FAIL sh_no_write: wb=%h required dead55ef", wb_data_out);
      end
      set_op(32'h12, 0, 5'd7, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'h0 || misalign_out !== 1'b1 || Regwrite_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL lw_misalign: wb=%h mis=%b rw=%b required 0 1 0",
                  wb_data_out, misalign_out, Regwrite_out);
      end
      pcm = 32'hFFFFFFFC;
      set_op(32'h0, 0, 5'd9, 2'b10, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'h0 || Regwrite_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL pc4_wrap: wb=%h rw=%b required 0 1", wb_data_out, Regwrite_out);
      end
      set_op(32'h1234, 0, 5'd0, 2'b01, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'h1234 || Regwrite_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL rd_zero: wb=%h rw=%b required 00001234 0", wb_data_out, Regwrite_out);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         en = ($urandom_range(0, 4) != 0);
         memrw = $urandom_range(0, 2) == 0;
         alu = $urandom;
         pcm = $urandom;
         data = $urandom;
         rd = 5'($urandom);
         rsel = 3'($urandom);
         wsel = 2'($urandom);
         regw = 1'($urandom);
         wbsel = memrw ? 2'($urandom_range(1, 3)) : 2'($urandom);
         apply_cycle();
         tests_run++;
         if (wb_data_out !== exp_wb || regdindex_out !== exp_rd ||
             Regwrite_out !== exp_rw || misalign_out !== exp_mis) begin
            tests_failed++;
            $display("FAIL random_%0d: wb=%h rd=%0d rw=%b mis=%b required %h %0d %b %b", n,
                     wb_data_out, regdindex_out, Regwrite_out, misalign_out,
                     exp_wb, exp_rd, exp_rw, exp_mis);
         end
      end
      en = 1'b1;
   endtask

   task automatic test_stall_reset();
      en = 1'b1;
      set_op(32'h20, 0, 5'd4, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      en = 1'b0;
      set_op(32'h20, 32'hA5A5_0F0F, 5'd9, 2'b01, 1'b1, 3'b010, 2'b10, 1'b1);
      apply_cycle(); apply_cycle();
      tests_run++;
      if (wb_data_out !== exp_wb || regdindex_out !== 5'd4 || Regwrite_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_hold: wb=%h rd=%0d rw=%b required %h 4 1",
                  wb_data_out, regdindex_out, Regwrite_out, exp_wb);
      end
      en = 1'b1;
      set_op(32'h20, 0, 5'd4, 2'b00, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== exp_wb || exp_wb === 32'hA5A5_0F0F) begin
         tests_failed++;
         $display("FAIL stall_no_store: wb=%h required %h", wb_data_out, exp_wb);
      end
      en = 1'b0;
      set_op(32'h3C, 32'h1, 5'd2, 2'b01, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      #3 rst = 1'b0;
      #1;
      tests_run++;
      if (wb_data_out !== 32'h0 || regdindex_out !== 5'h0 || Regwrite_out !== 1'b0 || misalign_out !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: wb=%h rd=%h rw=%b mis=%b required all zero",
                  wb_data_out, regdindex_out, Regwrite_out, misalign_out);
      end
      en = 1'b1;
      apply_cycle();
      rst = 1'b1;
      set_op(32'h3C, 32'h1, 5'd2, 2'b01, 1'b0, 3'b010, 2'b11, 1'b1); apply_cycle();
      tests_run++;
      if (wb_data_out !== 32'h3C || regdindex_out !== 5'd2 || Regwrite_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL post_reset_capture: wb=%h rd=%0d rw=%b required 0000003c 2 1",
                  wb_data_out, regdindex_out, Regwrite_out);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_directed();
      test_random();
      test_stall_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Parameters
REQ-001 datawidth, 32, data/address path width.
REQ-002 regindex, 5, register index width.
REQ-003 memwords, 256, data memory depth in 32-bit words; word address is ALU_in[9:2].

Interface
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 en  in  1  stage enable; 0 = stall (hold MEM/WB register, block stores).
REQ-008 ALU_in  in  32  memory address / ALU result from EX/MEM.
REQ-009 pcm_in  in  32  PC of the instruction.
REQ-010 datareg_in  in  32  store data (rs2).
REQ-011 regdindex_in  in  5  destination register index.
REQ-012 WBsel_in  in  2  writeback select: 00 load data, 01 ALU, 10 pcm_in+4, 11 zero.
REQ-013 MEMRw_in  in  1  1 = store, 0 = no store.
REQ-014 Rsel_in  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; other codes yield 0.
REQ-015 Wsel_in  in  2  store size: 00 sb, 01 sh, 10 sw, 11 none.
REQ-016 Regwrite_in  in  1  register write request.
REQ-017 wb_data_out  out  32  registered writeback value.
REQ-018 regdindex_out  out  5  registered destination index.
REQ-019 Regwrite_out  out  1  registered write enable to the register file.
REQ-020 misalign_out  out  1  registered misaligned-access flag.

Function
REQ-021 Memory read SHALL be combinational on the word at ALU_in[9:2]; ALU_in bits above 9 are ignored (address wraps modulo 1024 bytes).
REQ-022 Load extraction SHALL select byte lane ALU_in[1:0] (lb/lbu) or halfword lane ALU_in[1] (lh/lhu); lb/lh sign-extend, lbu/lhu zero-extend.
REQ-023 A store SHALL write on the rising clk edge iff en=1, MEMRw_in=1, Wsel_in!=11 and the access is aligned; sb writes lane ALU_in[1:0] with datareg_in[7:0], sh writes halfword ALU_in[1] with datareg_in[15:0], sw writes all four bytes.
REQ-024 Misaligned = (halfword access and ALU_in[0]=1) or (word access and ALU_in[1:0]!=00), where access size comes from Wsel_in if MEMRw_in=1, else from Rsel_in if WBsel_in=00.
REQ-025 A misaligned store SHALL NOT modify memory; a misaligned load SHALL produce load data 0.
REQ-026 On each rising edge with en=1, the MEM/WB register SHALL capture wb_data (per WBsel_in), regdindex_in, misalign and Regwrite_in AND (regdindex_in!=0) AND NOT misalign.
REQ-027 With en=0 all registered outputs SHALL hold and no memory write occurs.
REQ-028 Latency SHALL be exactly one cycle from inputs to registered outputs.
REQ-029 A load and a store to the same word in the same cycle is impossible (one instruction per cycle); a load in the cycle after a store SHALL see the new data.
REQ-030 pcm_in+4 SHALL wrap modulo 2^32.

Reset
REQ-031 While rst=0, wb_data_out, regdindex_out, Regwrite_out and misalign_out SHALL be 0, asynchronously.
REQ-032 Memory contents SHALL NOT be cleared by reset; a store coinciding with rst=0 SHALL NOT occur.
REQ-033 On rst release, the first rising edge with en=1 SHALL capture normally.

Verification
REQ-034 sw ALU=0x10, data=0xDEADBEEF; next lw ALU=0x10, WBsel=00, rd=5 -> wb_data_out=0xDEADBEEF, regdindex_out=5, Regwrite_out=1.
REQ-035 After REQ-034: lb ALU=0x13 -> 0xFFFFFFDE; lbu ALU=0x13 -> 0x000000DE; lh ALU=0x12 -> 0xFFFFDEAD; lhu ALU=0x10 -> 0x0000BEEF.
REQ-036 sb ALU=0x11 data=0x55 over 0xDEADBEEF, then lw 0x10 -> 0xDEAD55EF.
REQ-037 sh ALU=0x11 -> memory unchanged, misalign_out=1, Regwrite_out=0; lw ALU=0x12 -> wb_data_out=0, misalign_out=1.
REQ-038 WBsel=10 pcm=0xFFFFFFFC -> wb_data_out=0; WBsel=01 ALU=0x1234, rd=0, Regwrite_in=1 -> Regwrite_out=0.
REQ-039 Hold en=0 with sw pending -> outputs unchanged, memory unchanged; assert rst=0 mid-stall -> outputs 0 immediately without waiting for clk.
